// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Instruction-fetch sequencer for the single-cycle core. Owns the
//            fetch PC and drives the word address of a synchronous-read
//            instruction memory (1-cycle read latency, read every edge).
//            Delivers instructions to decode over a valid/ready handshake.
//            A 1-entry skid buffer preserves the word read during a decode
//            stall, and a redirect port serves branches and jumps.
//
// Ports    : clk            - clock, all state updates on rising edge
//            rst            - asynchronous, active-high reset
//            mem_addr       - word address to instruction memory
//            mem_rdata      - word at the address sampled on previous edge
//            redirect_valid - load a new PC this cycle (highest priority)
//            redirect_pc    - redirect target
//            inst_valid     - inst / inst_pc valid
//            inst_ready     - decode accepts when high with inst_valid
//            inst           - instruction
//            inst_pc        - word address of inst
//            halted         - fetch stopped on a halt instruction
//
// Options  : FETCH_HALT_EN - when defined, a transferred instruction with
//            opcode inst[31:26] == 6'b111111 stops fetch until redirect or
//            reset. When undefined that opcode is an ordinary instruction
//            and halted stays 0.
//
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int              AW       = 8,
    parameter int              DW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst,
    output logic [AW-1:0] inst_pc,
    output logic          halted
);

    typedef enum logic [0:0] {
        MODE_RUN  = 1'b0,
        MODE_HALT = 1'b1
    } mode_t;

`ifdef FETCH_HALT_EN
    localparam logic [5:0] c_HALT_OPCODE = 6'b111111;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0] fetch_pc_q,  fetch_pc_d;
    logic          rd_vld_q,    rd_vld_d;
    logic [AW-1:0] rd_pc_q,     rd_pc_d;
    logic          skid_vld_q,  skid_vld_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic [AW-1:0] skid_pc_q,   skid_pc_d;
    mode_t         mode_q,      mode_d;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [AW-1:0] w_mem_addr;
    logic          w_presented;
    logic          w_inst_valid;
    logic [DW-1:0] w_inst;
    logic [AW-1:0] w_inst_pc;
    logic          w_xfer;
    logic          w_halt_xfer;
    logic          w_issue;

    always_comb begin
        // A redirect steers the memory this very cycle so the target word
        // is available one edge later.
        w_mem_addr = redirect_valid ? redirect_pc : fetch_pc_q;

        w_presented  = skid_vld_q | rd_vld_q;
        w_inst_valid = w_presented & ~redirect_valid;

        // The skid entry is always older than anything in flight, so it
        // takes precedence. Outputs read as zero whenever nothing is valid.
        w_inst    = '0;
        w_inst_pc = '0;
        if (w_inst_valid) begin
            if (skid_vld_q) begin
                w_inst    = skid_data_q;
                w_inst_pc = skid_pc_q;
            end else begin
                w_inst    = mem_rdata;
                w_inst_pc = rd_pc_q;
            end
        end

        w_xfer = w_inst_valid & inst_ready;

`ifdef FETCH_HALT_EN
        w_halt_xfer = w_xfer & (w_inst[31:26] == c_HALT_OPCODE);
`else
        w_halt_xfer = 1'b0;
`endif

        // A new read may start whenever the presented slot will be free at
        // the next edge. A redirect always issues, even when halted or
        // stalled, because the presented entry is being discarded anyway.
        w_issue = redirect_valid
                | ((mode_q == MODE_RUN) & (~w_inst_valid | inst_ready) & ~w_halt_xfer);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rd_vld_d    = w_issue;
        rd_pc_d     = rd_pc_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;
        mode_d      = mode_q;

        if (w_issue) begin
            rd_pc_d    = w_mem_addr;
            // Natural wrap at 2^AW: the top word is followed by word 0.
            fetch_pc_d = w_mem_addr + AW'(1);
        end

        // Memory data is only valid for one cycle after its read edge, so a
        // stalled in-flight word must be parked in the skid entry. Since no
        // read is issued while stalled, the skid and the in-flight slot are
        // never occupied at the same time.
        if (redirect_valid) begin
            skid_vld_d = 1'b0;
        end else if (skid_vld_q & w_xfer) begin
            skid_vld_d = 1'b0;
        end else if (rd_vld_q & ~skid_vld_q & ~inst_ready) begin
            skid_vld_d  = 1'b1;
            skid_data_d = mem_rdata;
            skid_pc_d   = rd_pc_q;
        end

        if (redirect_valid) begin
            mode_d = MODE_RUN;
        end else if (w_halt_xfer) begin
            mode_d = MODE_HALT;
        end
    end

    // ------------------------------------------------------------------
    // Registers (async reset discards everything in flight immediately)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            rd_vld_q    <= 1'b0;
            rd_pc_q     <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_pc_q   <= '0;
            mode_q      <= MODE_RUN;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rd_vld_q    <= rd_vld_d;
            rd_pc_q     <= rd_pc_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_pc_q   <= skid_pc_d;
            mode_q      <= mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_addr   = w_mem_addr;
    assign inst_valid = w_inst_valid;
    assign inst       = w_inst;
    assign inst_pc    = w_inst_pc;
    assign halted     = (mode_q == MODE_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Self-checking bench for fetch_ctrl. A sequence-level model
//            tracks which PC decode should be seeing each cycle and checks
//            the DUT every cycle; directed literal checks pin key points.
//            Honours FETCH_HALT_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam int            AW       = 8;
    localparam int            DW       = 32;
    localparam logic [AW-1:0] RESET_PC = 8'h00;

    logic          clk            = 1'b0;
    logic          rst            = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata      = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc    = '0;
    logic          inst_valid;
    logic          inst_ready     = 1'b0;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          halted;

    fetch_ctrl #(
        .AW       (AW),
        .DW       (DW),
        .RESET_PC (RESET_PC)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory, 1-cycle latency.
    logic [DW-1:0] mem [256];
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit is_halt(input logic [DW-1:0] w);
`ifdef FETCH_HALT_EN
        return (w[31:26] == 6'b111111);
`else
        return 1'b0;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Sequence model: m_pc is the PC decode must see, m_valid says whether
    // something is presented, m_halt whether fetch has stopped. The next
    // fetch address is always the one after the presented (or last halted)
    // PC, or m_next before anything has been presented.
    // ------------------------------------------------------------------
    logic          m_valid = 1'b0;
    logic          m_halt  = 1'b0;
    logic [AW-1:0] m_pc    = '0;
    logic [AW-1:0] m_next  = RESET_PC;

    always begin
        logic          exp_valid;
        logic [AW-1:0] exp_addr;
        @(negedge clk);
        #2;
        if (rst) begin
            chk("m_rst_valid",  32'(inst_valid), 32'd0);
            chk("m_rst_halted", 32'(halted),     32'd0);
            chk("m_rst_addr",   32'(mem_addr),   32'(RESET_PC));
            m_valid = 1'b0;
            m_halt  = 1'b0;
            m_next  = RESET_PC;
        end else begin
            exp_valid = m_valid & ~redirect_valid;
            if (redirect_valid)
                exp_addr = redirect_pc;
            else if (m_valid | m_halt)
                exp_addr = m_pc + 8'd1;
            else
                exp_addr = m_next;
            chk("m_valid",  32'(inst_valid), 32'(exp_valid));
            chk("m_halted", 32'(halted),     32'(m_halt));
            chk("m_addr",   32'(mem_addr),   32'(exp_addr));
            if (exp_valid) begin
                chk("m_inst",    inst,          mem[m_pc]);
                chk("m_inst_pc", 32'(inst_pc),  32'(m_pc));
            end
            if (redirect_valid) begin
                m_valid = 1'b1;
                m_pc    = redirect_pc;
                m_halt  = 1'b0;
            end else if (m_halt) begin
                m_valid = 1'b0;
            end else if (!m_valid) begin
                m_valid = 1'b1;
                m_pc    = m_next;
            end else if (inst_ready) begin
                if (is_halt(mem[m_pc])) begin
                    m_valid = 1'b0;
                    m_halt  = 1'b1;
                end else begin
                    m_pc = m_pc + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic step(input logic rdy, input logic rv, input logic [AW-1:0] rpc);
        @(negedge clk);
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #3;
    endtask

    task automatic see(input string name, input logic [AW-1:0] pc);
        chk({name, "_valid"}, 32'(inst_valid), 32'd1);
        chk({name, "_pc"},    32'(inst_pc),    32'(pc));
        chk({name, "_inst"},  inst,            mem[pc]);
    endtask

    initial begin
        logic [19:0] pat;
        pat = 20'b1101_0011_1011_0001_1111;

        for (int i = 0; i < 256; i++) mem[i] = 32'h1234_0000 | 32'(i * 3 + 1);
        mem[3] = 32'hFC00_0000;

        // Reset state.
        repeat (2) @(negedge clk);
        #3;
        chk("rst_valid",   32'(inst_valid), 32'd0);
        chk("rst_halted",  32'(halted),     32'd0);
        chk("rst_addr",    32'(mem_addr),   32'(RESET_PC));
        chk("rst_inst",    inst,            32'd0);
        chk("rst_inst_pc", 32'(inst_pc),    32'd0);

        // Release: first instruction one cycle later, then back to back.
        @(negedge clk);
        rst = 1'b0;
        inst_ready = 1'b1;
        #3;
        chk("first_gap", 32'(inst_valid), 32'd0);
        step(1'b1, 1'b0, '0); see("a0", 8'h00);
        chk("a0_literal", inst, 32'h1234_0001);

        // Stall three cycles on B/1.
        step(1'b0, 1'b0, '0); see("stall1", 8'h01);
        step(1'b0, 1'b0, '0); see("stall2", 8'h01);
        step(1'b0, 1'b0, '0); see("stall3", 8'h01);
        step(1'b1, 1'b0, '0); see("b1", 8'h01);
        step(1'b1, 1'b0, '0); see("c2", 8'h02);
        step(1'b1, 1'b0, '0); see("d3", 8'h03);
        chk("d3_literal", inst, 32'hFC00_0000);
        step(1'b1, 1'b0, '0);
`ifdef FETCH_HALT_EN
        chk("halt_flag",  32'(halted),     32'd1);
        chk("halt_valid", 32'(inst_valid), 32'd0);
        step(1'b1, 1'b0, '0);
        chk("halt_hold",  32'(inst_valid), 32'd0);
`else
        see("e4", 8'h04);
        chk("nohalt_flag", 32'(halted), 32'd0);
        step(1'b1, 1'b0, '0); see("f5", 8'h05);
`endif

        // Redirect to 0 resumes.
        step(1'b1, 1'b1, 8'h00);
        chk("redir0_valid", 32'(inst_valid), 32'd0);
        step(1'b1, 1'b0, '0); see("r0", 8'h00);
        chk("r0_halted", 32'(halted), 32'd0);

        // Fill skid, then redirect while stalled.
        step(1'b0, 1'b0, '0); see("sk1", 8'h01);
        step(1'b0, 1'b0, '0); see("sk2", 8'h01);
        step(1'b0, 1'b1, 8'h40);
        chk("redir40_valid", 32'(inst_valid), 32'd0);
        chk("redir40_addr",  32'(mem_addr),   32'h40);
        step(1'b1, 1'b0, '0); see("r40", 8'h40);
        step(1'b1, 1'b0, '0); see("r41", 8'h41);

        // Wrap around the top of the address space.
        step(1'b1, 1'b1, 8'hFE);
        step(1'b1, 1'b0, '0); see("wFE", 8'hFE);
        step(1'b1, 1'b0, '0); see("wFF", 8'hFF);
        step(1'b1, 1'b0, '0); see("w00", 8'h00);

        // Asynchronous reset during a stall.
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_valid",  32'(inst_valid), 32'd0);
        chk("async_rst_halted", 32'(halted),     32'd0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        inst_ready = 1'b1;
        #3;
        chk("restart_gap", 32'(inst_valid), 32'd0);
        step(1'b1, 1'b0, '0); see("restart", RESET_PC);

        // Mixed ready pattern with a redirect in the middle.
        for (int i = 0; i < 20; i++) begin
            if (i == 10) step(pat[i], 1'b1, 8'h80);
            else         step(pat[i], 1'b0, '0);
        end
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the single-cycle core. Owns the fetch PC, drives the address of the synchronous-read instruction memory (word-addressed, 1-cycle read latency, read every clock edge), and delivers instructions to decode over a valid/ready handshake. A 1-entry skid buffer preserves data across decode stalls, and a redirect port serves branches and jumps.

## Interface
- AW, 8: word-address width (256-word memory)
- DW, 32: instruction width
- RESET_PC, 0: first fetch address after reset
---
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_addr  out  AW  word address to instruction memory, sampled by memory on each rising edge
- mem_rdata  in  DW  memory data; holds word at address sampled on the previous edge
- redirect_valid  in  1  load new PC this cycle
- redirect_pc  in  AW  redirect target
- inst_valid  out  1  inst/inst_pc valid
- inst_ready  in  1  decode accepts when high with inst_valid
- inst  out  DW  instruction
- inst_pc  out  AW  word address of inst
- halted  out  1  fetch stopped on halt instruction

## Operation
- State: fetch_pc (AW), rd_vld/rd_pc (read in flight), skid_vld/skid_data/skid_pc, mode ∈ {RUN, HALT}.
- mem_addr = redirect_valid ? redirect_pc : fetch_pc (combinational).
- Presented entry: skid if skid_vld, else memory read if rd_vld. Invariant: skid_vld and rd_vld never both 1.
- inst_valid = (skid_vld | rd_vld) & ~redirect_valid; inst/inst_pc from skid or (mem_rdata, rd_pc); transfer = inst_valid & inst_ready.
- issue = (mode==RUN) & (~inst_valid | inst_ready) & ~halt_xfer. On issue: rd_vld←1, rd_pc←mem_addr, fetch_pc←mem_addr+1 (mod 2^AW, 255→0 wraps). Otherwise rd_vld←0.
- Stall capture: rd_vld & ~skid_vld & ~inst_ready & ~redirect_valid → skid←(mem_rdata, rd_pc), skid_vld←1.
- skid_vld←0 on transfer of skid entry.
- Redirect (highest priority): presented entry dropped, skid_vld←0, mode←RUN, read issued at redirect_pc regardless of ready/halt.
- halted = (mode==HALT).

## Timing
- Reset values: fetch_pc=RESET_PC, rd_vld=0, skid_vld=0, mode=RUN; so inst_valid=0, halted=0, mem_addr=RESET_PC; inst/inst_pc=0 while invalid.
- First edge after reset release issues RESET_PC; inst_valid=1 with Memory[RESET_PC] after that edge. Fetch-to-decode latency 1 cycle.
- Ready held high: one instruction per cycle, consecutive PCs, no bubbles.
- Ready low: presented instruction and inst_pc held stable until accepted; no instruction lost or duplicated. Release of ready gives back-to-back delivery with no bubble.
- Redirect in cycle N: no transfer in N; redirect_pc instruction valid in N+1.
- Redirect and stall same cycle: redirect wins.
- Reset mid-stream: all in-flight/skid data discarded immediately (async).

## Configuration
- FETCH_HALT_EN defined: a presented instruction with inst[31:26]==6'b111111 that transfers sets halt_xfer; issue suppressed that cycle, mode←HALT, halt instruction still delivered, no further inst_valid until redirect or reset.
- Undefined: opcode 111111 treated as ordinary instruction; halted tied 0; mode stays RUN.

## Test plan
- Reset release, ready=1, Memory[0..2]=A,B,C -> inst_valid rises one cycle later; A/0, B/1, C/2 on consecutive cycles.
- Ready low 3 cycles while B/1 presented -> B/1 held stable; after release B, C, D delivered back-to-back, none repeated or skipped.
- redirect_valid with redirect_pc=0x40 while stalled with skid full -> no transfer that cycle, next cycle inst_pc=0x40, skid cleared.
- Fetch from 0xFE with ready=1 -> inst_pc sequence 0xFE, 0xFF, 0x00.
- FETCH_HALT_EN, Memory[3]=0xFC000000 -> instruction 3 delivered, halted=1, inst_valid=0 afterward; redirect to 0 resumes with halted=0. Without macro: fetch continues to 4.
- rst asserted during stall -> inst_valid=0 immediately; after release fetch restarts at RESET_PC.
